// File: rtl/instruction_encoder.sv
// instruction_encoder: symbolic 6502 instruction -> opcode plus little-endian operand bytes.
// Illegal mnemonic/mode pairs are dropped with an err pulse and a saturating count.
module instruction_encoder #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_cmd,
    input  logic [4:0]       in_addr,
    input  logic [15:0]      in_operand,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_byte,
    output logic             out_first,
    output logic             out_last,
    output logic             err,
    output logic [ERR_W-1:0] err_count
);
    typedef enum logic [1:0] {IDLE, OPC, LO, HI} state_t;

    localparam logic [31:0] M_A   = 32'd1 << 0;
    localparam logic [31:0] M_ABS = 32'd1 << 1;
    localparam logic [31:0] M_ABX = 32'd1 << 2;
    localparam logic [31:0] M_ABY = 32'd1 << 3;
    localparam logic [31:0] M_IMM = 32'd1 << 4;
    localparam logic [31:0] M_IMP = 32'd1 << 5;
    localparam logic [31:0] M_IND = 32'd1 << 6;
    localparam logic [31:0] M_REL = 32'd1 << 9;
    localparam logic [31:0] M_ZP  = 32'd1 << 10;
    localparam logic [31:0] M_ZX  = 32'd1 << 11;
    localparam logic [31:0] M_ZY  = 32'd1 << 12;

    state_t      state;
    logic [15:0] operand;
    logic [1:0]  len_q;
    logic [4:0]  m;
    logic [1:0]  len;
    logic [7:0]  opc;
    logic [7:0]  base;
    logic [7:0]  off;
    logic [2:0]  bbb;
    logic [31:0] mask;
    logic        ok;
    logic        alu;
    logic        fixed;
    logic        bbb_ok;

    assign in_ready = (state == IDLE);

    always_comb begin
        m = (in_addr == 5'd13) ? 5'd5 : in_addr;
        case (m)
            5'd0, 5'd5:             len = 2'd1;
            5'd1, 5'd2, 5'd3, 5'd6: len = 2'd3;
            default:                len = 2'd2;
        endcase
        // column bits of the cc=01 ALU group
        bbb_ok = 1'b1;
        case (m)
            5'd7:    bbb = 3'd0;
            5'd10:   bbb = 3'd1;
            5'd4:    bbb = 3'd2;
            5'd1:    bbb = 3'd3;
            5'd8:    bbb = 3'd4;
            5'd11:   bbb = 3'd5;
            5'd3:    bbb = 3'd6;
            5'd2:    bbb = 3'd7;
            default: begin bbb = 3'd0; bbb_ok = 1'b0; end
        endcase
        // column offsets shared by the cc=00/10 groups
        case (m)
            5'd0, 5'd5:   off = 8'h08;
            5'd10:        off = 8'h04;
            5'd1:         off = 8'h0C;
            5'd11, 5'd12: off = 8'h14;
            5'd2, 5'd3:   off = 8'h1C;
            default:      off = 8'h00;
        endcase
        case (in_cmd)
            6'd1:  base = 8'h60;  6'd2:  base = 8'h20;  6'd3:  base = 8'h02;
            6'd4:  base = 8'h90;  6'd5:  base = 8'hB0;  6'd6:  base = 8'hF0;
            6'd7:  base = 8'h20;  6'd8:  base = 8'h30;  6'd9:  base = 8'hD0;
            6'd10: base = 8'h10;  6'd11: base = 8'h00;  6'd12: base = 8'h50;
            6'd13: base = 8'h70;  6'd14: base = 8'h18;  6'd15: base = 8'hD8;
            6'd16: base = 8'h58;  6'd17: base = 8'hB8;  6'd18: base = 8'hC0;
            6'd19: base = 8'hE0;  6'd20: base = 8'hC0;  6'd21: base = 8'hC2;
            6'd22: base = 8'hCA;  6'd23: base = 8'h88;  6'd24: base = 8'h40;
            6'd25: base = 8'hE2;  6'd26: base = 8'hE8;  6'd27: base = 8'hC8;
            6'd28: base = (m == 5'd6) ? 8'h6C : 8'h4C;
            6'd29: base = 8'h20;  6'd30: base = 8'hA0;  6'd31: base = 8'hA2;
            6'd32: base = 8'hA0;  6'd33: base = 8'h42;  6'd34: base = 8'hEA;
            6'd35: base = 8'h00;  6'd36: base = 8'h48;  6'd37: base = 8'h08;
            6'd38: base = 8'h68;  6'd39: base = 8'h28;  6'd40: base = 8'h22;
            6'd41: base = 8'h62;  6'd42: base = 8'h40;  6'd43: base = 8'h60;
            6'd44: base = (m == 5'd5) ? 8'h38 : 8'hE0;
            6'd45: base = 8'hF8;  6'd46: base = 8'h78;  6'd47: base = 8'h80;
            6'd48: base = 8'h82;  6'd49: base = 8'h80;  6'd50: base = 8'hAA;
            6'd51: base = 8'hA8;  6'd52: base = 8'hBA;  6'd53: base = 8'h8A;
            6'd54: base = 8'h9A;  6'd55: base = 8'h02;  6'd56: base = 8'h22;
            6'd57: base = 8'h42;  6'd58: base = 8'h62;  6'd59: base = 8'h98;
            default: base = 8'h00;
        endcase
        alu   = 1'b0;
        fixed = 1'b0;
        mask  = '0;
        case (in_cmd)
            6'd1, 6'd2, 6'd18, 6'd24, 6'd30, 6'd35, 6'd47: alu = 1'b1;
            6'd44:
                if (m == 5'd5) begin fixed = 1'b1; mask = M_IMP; end
                else alu = 1'b1;
            6'd4, 6'd5, 6'd6, 6'd8, 6'd9, 6'd10, 6'd12, 6'd13:
                begin fixed = 1'b1; mask = M_REL; end
            6'd11, 6'd14, 6'd15, 6'd16, 6'd17, 6'd22, 6'd23, 6'd26,
            6'd27, 6'd34, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd43,
            6'd45, 6'd46, 6'd50, 6'd51, 6'd52, 6'd53, 6'd54, 6'd59:
                begin fixed = 1'b1; mask = M_IMP; end
            6'd3, 6'd33, 6'd40, 6'd41: mask = M_A | M_ZP | M_ZX | M_ABS | M_ABX;
            6'd55, 6'd56, 6'd57, 6'd58: mask = M_A | M_IMP;
            6'd7:        mask = M_ZP | M_ABS;
            6'd19, 6'd20: mask = M_IMM | M_ZP | M_ABS;
            6'd21, 6'd25: mask = M_ZP | M_ZX | M_ABS | M_ABX;
            6'd28:       begin fixed = 1'b1; mask = M_ABS | M_IND; end
            6'd29:       begin fixed = 1'b1; mask = M_ABS; end
            6'd31:       mask = M_IMM | M_ZP | M_ZY | M_ABS | M_ABY;
            6'd32:       mask = M_IMM | M_ZP | M_ZX | M_ABS | M_ABX;
            6'd48:       mask = M_ZP | M_ZY | M_ABS;
            6'd49:       mask = M_ZP | M_ZX | M_ABS;
            default:     mask = '0;
        endcase
        if (alu) begin
            ok  = bbb_ok && !(in_cmd == 6'd47 && m == 5'd4);
            opc = base | {bbb, 2'b01};
        end else begin
            ok  = mask[m];
            opc = fixed ? base : (base | off);
        end
        if (in_addr > 5'd13) ok = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            operand   <= '0;
            len_q     <= 2'd0;
            out_valid <= 1'b0;
            out_byte  <= 8'h00;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: if (in_valid) begin
                    if (ok) begin
                        state     <= OPC;
                        operand   <= in_operand;
                        len_q     <= len;
                        out_valid <= 1'b1;
                        out_byte  <= opc;
                        out_first <= 1'b1;
                        out_last  <= (len == 2'd1);
                    end else begin
                        err <= 1'b1;
                        if (err_count != '1) err_count <= err_count + 1'b1;
                    end
                end
                OPC: if (out_ready) begin
                    out_first <= 1'b0;
                    if (len_q == 2'd1) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_byte  <= 8'h00;
                        out_last  <= 1'b0;
                    end else begin
                        state    <= LO;
                        out_byte <= operand[7:0];
                        out_last <= (len_q == 2'd2);
                    end
                end
                LO: if (out_ready) begin
                    if (len_q == 2'd2) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_byte  <= 8'h00;
                        out_last  <= 1'b0;
                    end else begin
                        state    <= HI;
                        out_byte <= operand[15:8];
                        out_last <= 1'b1;
                    end
                end
                HI: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_byte  <= 8'h00;
                    out_last  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_encoder.sv
// Bench for instruction_encoder: flat opcode table model, byte scoreboard, err tracking.
// CMD codes are the alphabetical mnemonic list (SEC shares 44), ASLA..RORA 55-58, TYA 59.
module tb_instruction_encoder;
    localparam int N = -1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_cmd = '0;
    logic [4:0]  in_addr = '0;
    logic [15:0] in_operand = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_byte;
    logic        out_first;
    logic        out_last;
    logic        err;
    logic [7:0]  err_count;

    logic        in2_valid = 1'b0;
    logic        in2_ready;
    logic        out2_valid;
    logic        out2_ready = 1'b1;
    logic [7:0]  out2_byte;
    logic        out2_first;
    logic        out2_last;
    logic        err2;
    logic [1:0]  err2_count;

    always #5 clk = ~clk;

    instruction_encoder #(.ERR_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_cmd(in_cmd), .in_addr(in_addr), .in_operand(in_operand),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_byte(out_byte), .out_first(out_first), .out_last(out_last),
        .err(err), .err_count(err_count)
    );

    instruction_encoder #(.ERR_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in2_valid), .in_ready(in2_ready),
        .in_cmd(6'd0), .in_addr(5'd5), .in_operand(16'h0000),
        .out_valid(out2_valid), .out_ready(out2_ready),
        .out_byte(out2_byte), .out_first(out2_first), .out_last(out2_last),
        .err(err2), .err_count(err2_count)
    );

    typedef struct packed {
        logic [7:0] b;
        logic       f;
        logic       l;
    } exp_t;

    int   tbl[64][13];
    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   err_exp = 0;
    int   err_seen = 0;
    int   model_cnt = 0;
    int   err2_seen = 0;
    int   out2_seen = 0;
    bit   rnd_rdy = 0;
    bit   force_rdy = 1;
    bit   held_v = 0;
    logic [10:0] held;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got event want none at %0t", name, $time);
    endtask

    function automatic void model(input int c, input int a, output int op,
                                  output int n, output bit ok);
        int m;
        m  = (a == 13) ? 5 : a;
        ok = 0;
        op = 0;
        if (c >= 1 && c <= 59 && a <= 13 && tbl[c][m] >= 0) begin
            ok = 1;
            op = tbl[c][m];
        end
        if (m == 0 || m == 5) n = 1;
        else if (m == 1 || m == 2 || m == 3 || m == 6) n = 3;
        else n = 2;
    endfunction

    task automatic send(input int c, input int a, input logic [15:0] opnd);
        int op, n, k;
        bit ok;
        exp_t e;
        @(negedge clk);
        in_cmd     = c[5:0];
        in_addr    = a[4:0];
        in_operand = opnd;
        in_valid   = 1'b1;
        k = 0;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            fail("accept_timeout");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model(c, a, op, n, ok);
        if (ok) begin
            e = '{b: op[7:0], f: 1'b1, l: (n == 1)};
            sb.push_back(e);
            if (n > 1) sb.push_back('{b: opnd[7:0], f: 1'b0, l: (n == 2)});
            if (n > 2) sb.push_back('{b: opnd[15:8], f: 1'b0, l: 1'b1});
        end else begin
            err_exp++;
            if (model_cnt < 255) model_cnt++;
        end
    endtask

    task automatic wait_idle(input int k, input string name);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        check(name, n, k);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) fail("drain_timeout");
    endtask

    always @(posedge clk) begin
        #1;
        out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            held_v = 0;
        end else begin
            if (held_v)
                check("stall_hold", {out_valid, out_byte, out_first, out_last}, held);
            if (err) begin
                err_seen++;
                if (err_exp > 0) begin
                    err_exp--;
                    check("err_count", err_count, model_cnt);
                end else begin
                    fail("unexpected_err");
                end
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    fail("unexpected_byte");
                end else begin
                    e = sb.pop_front();
                    check("byte", out_byte, e.b);
                    check("first", out_first, e.f);
                    check("last", out_last, e.l);
                end
            end
            held_v = out_valid && !out_ready;
            held   = {out_valid, out_byte, out_first, out_last};
        end
    end

    always @(negedge clk) begin
        if (err2) err2_seen++;
        if (out2_valid) out2_seen++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, a, s0;
        for (int i = 0; i < 64; i++)
            for (int j = 0; j < 13; j++) tbl[i][j] = N;
        //           A    abs  absX absY imm  impl ind  Xind indY rel  zpg  zpgX zpgY
        tbl[1]  = '{N,  'h6D,'h7D,'h79,'h69,N,   N,  'h61,'h71,N,  'h65,'h75,N};
        tbl[2]  = '{N,  'h2D,'h3D,'h39,'h29,N,   N,  'h21,'h31,N,  'h25,'h35,N};
        tbl[3]  = '{'h0A,'h0E,'h1E,N,  N,   N,   N,  N,   N,   N,  'h06,'h16,N};
        tbl[7]  = '{N,  'h2C,N,   N,   N,   N,   N,  N,   N,   N,  'h24,N,   N};
        tbl[18] = '{N,  'hCD,'hDD,'hD9,'hC9,N,   N,  'hC1,'hD1,N,  'hC5,'hD5,N};
        tbl[19] = '{N,  'hEC,N,   N,   'hE0,N,   N,  N,   N,   N,  'hE4,N,   N};
        tbl[20] = '{N,  'hCC,N,   N,   'hC0,N,   N,  N,   N,   N,  'hC4,N,   N};
        tbl[21] = '{N,  'hCE,'hDE,N,   N,   N,   N,  N,   N,   N,  'hC6,'hD6,N};
        tbl[24] = '{N,  'h4D,'h5D,'h59,'h49,N,   N,  'h41,'h51,N,  'h45,'h55,N};
        tbl[25] = '{N,  'hEE,'hFE,N,   N,   N,   N,  N,   N,   N,  'hE6,'hF6,N};
        tbl[28] = '{N,  'h4C,N,   N,   N,   N,  'h6C,N,   N,   N,  N,   N,   N};
        tbl[29] = '{N,  'h20,N,   N,   N,   N,   N,  N,   N,   N,  N,   N,   N};
        tbl[30] = '{N,  'hAD,'hBD,'hB9,'hA9,N,   N,  'hA1,'hB1,N,  'hA5,'hB5,N};
        tbl[31] = '{N,  'hAE,N,   'hBE,'hA2,N,   N,  N,   N,   N,  'hA6,N,  'hB6};
        tbl[32] = '{N,  'hAC,'hBC,N,   'hA0,N,   N,  N,   N,   N,  'hA4,'hB4,N};
        tbl[33] = '{'h4A,'h4E,'h5E,N,  N,   N,   N,  N,   N,   N,  'h46,'h56,N};
        tbl[35] = '{N,  'h0D,'h1D,'h19,'h09,N,   N,  'h01,'h11,N,  'h05,'h15,N};
        tbl[40] = '{'h2A,'h2E,'h3E,N,  N,   N,   N,  N,   N,   N,  'h26,'h36,N};
        tbl[41] = '{'h6A,'h6E,'h7E,N,  N,   N,   N,  N,   N,   N,  'h66,'h76,N};
        tbl[44] = '{N,  'hED,'hFD,'hF9,'hE9,'h38,N,  'hE1,'hF1,N,  'hE5,'hF5,N};
        tbl[47] = '{N,  'h8D,'h9D,'h99,N,   N,   N,  'h81,'h91,N,  'h85,'h95,N};
        tbl[48] = '{N,  'h8E,N,   N,   N,   N,   N,  N,   N,   N,  'h86,N,  'h96};
        tbl[49] = '{N,  'h8C,N,   N,   N,   N,   N,  N,   N,   N,  'h84,'h94,N};
        tbl[4][9] = 'h90;  tbl[5][9] = 'hB0;  tbl[6][9] = 'hF0;  tbl[8][9] = 'h30;
        tbl[9][9] = 'hD0;  tbl[10][9] = 'h10; tbl[12][9] = 'h50; tbl[13][9] = 'h70;
        tbl[11][5] = 'h00; tbl[14][5] = 'h18; tbl[15][5] = 'hD8; tbl[16][5] = 'h58;
        tbl[17][5] = 'hB8; tbl[22][5] = 'hCA; tbl[23][5] = 'h88; tbl[26][5] = 'hE8;
        tbl[27][5] = 'hC8; tbl[34][5] = 'hEA; tbl[36][5] = 'h48; tbl[37][5] = 'h08;
        tbl[38][5] = 'h68; tbl[39][5] = 'h28; tbl[42][5] = 'h40; tbl[43][5] = 'h60;
        tbl[45][5] = 'hF8; tbl[46][5] = 'h78; tbl[50][5] = 'hAA; tbl[51][5] = 'hA8;
        tbl[52][5] = 'hBA; tbl[53][5] = 'h8A; tbl[54][5] = 'h9A; tbl[59][5] = 'h98;
        tbl[55][0] = 'h0A; tbl[55][5] = 'h0A; tbl[56][0] = 'h2A; tbl[56][5] = 'h2A;
        tbl[57][0] = 'h4A; tbl[57][5] = 'h4A; tbl[58][0] = 'h6A; tbl[58][5] = 'h6A;

        // reset state, with a legal request offered while reset is held
        in_cmd = 6'd34; in_addr = 5'd5; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_byte", out_byte, 0);
        check("rst_out_first", out_first, 0);
        check("rst_out_last", out_last, 0);
        check("rst_err", err, 0);
        check("rst_err_count", err_count, 0);
        in_valid = 1'b0;
        rst = 1'b0;

        send(30, 4, 16'h0042);
        wait_idle(2, "lda_imm_busy");
        send(28, 6, 16'h1234);
        @(negedge clk);
        force_rdy = 0;
        repeat (3) @(negedge clk);
        force_rdy = 1;
        drain();
        send(34, 5, 16'hBEEF);
        wait_idle(1, "nop_busy");
        send(44, 5, 16'h0000);
        wait_idle(1, "sec_busy");
        send(44, 3, 16'h2000);
        wait_idle(3, "sbc_absy_busy");
        send(55, 13, 16'h0000);
        wait_idle(1, "asla_busy");

        s0 = err_seen;
        send(47, 4, 16'h0011);
        send(0, 5, 16'h0000);
        repeat (2) @(negedge clk);
        check("illegal_pulses", err_seen - s0, 2);
        check("illegal_count", err_count, 2);
        check("illegal_out_valid", out_valid, 0);
        check("illegal_in_ready", in_ready, 1);

        @(negedge clk);
        in2_valid = 1'b1;
        repeat (5) @(negedge clk);
        in2_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("sat_pulses", err2_seen, 5);
        check("sat_count", err2_count, 3);
        check("sat_no_output", out2_seen, 0);

        send(47, 1, 16'h0300);
        @(posedge clk);
        #2;
        rst = 1'b1;
        sb.delete();
        err_exp = 0;
        model_cnt = 0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_err_count", err_count, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);

        rnd_rdy = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 8) begin
                c = $urandom_range(1, 59);
                a = $urandom_range(0, 13);
            end else begin
                c = $urandom_range(0, 63);
                a = $urandom_range(0, 31);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(c, a, 16'($urandom));
        end
        drain();
        rnd_rdy = 0;
        repeat (3) @(negedge clk);
        check("final_sb_empty", sb.size(), 0);
        check("final_err_pending", err_exp, 0);
        check("final_err_count", err_count, model_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
